next_pc_predict_gen2: RTL

//  Second-generation fetch-stage next-PC predictor: BTB + BHT (bimodal/gshare) + RAS.

---
 rtl/next_pc_predict_gen2.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/next_pc_predict_gen2.sv
// rtl/next_pc_predict_gen2.sv - fetch-stage next-PC predictor (BTB + bimodal/gshare BHT + RAS)
// Lookup is combinational from pc_f_i; all training arrives from execute-stage resolution.
module next_pc_predict_gen2 #(
  parameter int         FETCH_W     = 2,
  parameter int         BTB_ENTRIES = 16,
  parameter int         BTB_W       = 4,
  parameter int         BHT_ENTRIES = 256,
  parameter int         BHT_W       = 8,
  parameter int         RAS_DEPTH   = 8,
  parameter int         RAS_W       = 3,
  parameter int         GSHARE      = 1,
  parameter logic [1:0] BHT_INIT    = 2'd1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               invalidate_i,
  input  logic               branch_request_i,
  input  logic               branch_is_taken_i,
  input  logic               branch_is_not_taken_i,
  input  logic [31:0]        branch_source_i,
  input  logic [31:0]        branch_pc_i,
  input  logic               branch_is_call_i,
  input  logic               branch_is_ret_i,
  input  logic               branch_is_jmp_i,
  input  logic [31:0]        pc_f_i,
  input  logic               pc_accept_i,
  output logic [31:0]        next_pc_f_o,
  output logic [FETCH_W-1:0] next_taken_f_o
);

  localparam int               SLOT_W    = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam logic [31:0]      BLK_BYTES = 32'(4 * FETCH_W);
  localparam logic [31:0]      BLK_MASK  = 32'(4 * FETCH_W - 1);
  localparam logic [BTB_W-1:0] BTB_LAST  = BTB_W'(BTB_ENTRIES - 1);
  localparam logic [RAS_W:0]   RAS_FULL  = (RAS_W + 1)'(RAS_DEPTH);

  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [BTB_ENTRIES-1:0] btb_call_q, btb_call_d;
  logic [BTB_ENTRIES-1:0] btb_ret_q, btb_ret_d;
  logic [BTB_ENTRIES-1:0] btb_jmp_q, btb_jmp_d;
  logic [31:0]            btb_pc_q [BTB_ENTRIES];
  logic [31:0]            btb_pc_d [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_d [BTB_ENTRIES];
  logic [BTB_W-1:0]       alloc_ptr_q, alloc_ptr_d;

  logic [1:0]             bht_q [BHT_ENTRIES];
  logic [1:0]             bht_d [BHT_ENTRIES];
  logic [BHT_W-1:0]       ghr_real_q, ghr_real_d;
  logic [BHT_W-1:0]       ghr_spec_q, ghr_spec_d;

  logic [31:0]            ras_q [RAS_DEPTH];
  logic [31:0]            ras_d [RAS_DEPTH];
  logic [RAS_W-1:0]       ras_ptr_real_q, ras_ptr_real_d;
  logic [RAS_W-1:0]       ras_ptr_spec_q, ras_ptr_spec_d;
  logic [RAS_W:0]         ras_cnt_real_q, ras_cnt_real_d;
  logic [RAS_W:0]         ras_cnt_spec_q, ras_cnt_spec_d;

  function automatic logic [BHT_W-1:0] bht_idx(input logic [31:0] pc, input logic [BHT_W-1:0] ghr);
    return (GSHARE != 0) ? (ghr ^ pc[2 +: BHT_W]) : pc[2 +: BHT_W];
  endfunction

  // Per-slot BTB match and taken decision for the current fetch block
  logic [31:0]        pc_base;
  logic [SLOT_W-1:0]  start_slot;
  logic [31:0]        slot_pc [FETCH_W];
  logic [BTB_W-1:0]   slot_idx [FETCH_W];
  logic [FETCH_W-1:0] slot_hit, slot_cond, slot_taken;

  always_comb begin
    pc_base    = pc_f_i & ~BLK_MASK;
    start_slot = '0;
    if (FETCH_W > 1) start_slot = pc_f_i[2 +: SLOT_W];
    slot_hit   = '0;
    slot_cond  = '0;
    slot_taken = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      slot_pc[s]  = pc_base + 32'(4 * s);
      slot_idx[s] = '0;
      for (int e = 0; e < BTB_ENTRIES; e++) begin
        if (!slot_hit[s] && btb_valid_q[e] && (btb_pc_q[e] == slot_pc[s])) begin
          slot_hit[s] = 1'b1;
          slot_idx[s] = BTB_W'(e);
        end
      end
      slot_cond[s]  = slot_hit[s] && !(btb_jmp_q[slot_idx[s]] || btb_ret_q[slot_idx[s]] ||
                                       btb_call_q[slot_idx[s]]);
      slot_taken[s] = slot_hit[s] && (btb_jmp_q[slot_idx[s]] || btb_call_q[slot_idx[s]] ||
                      (btb_ret_q[slot_idx[s]] && (ras_cnt_spec_q != '0)) ||
                      (slot_cond[s] && bht_q[bht_idx(slot_pc[s], ghr_spec_q)][1]));
    end
  end

  logic               win_found, win_call, win_ret, win_cond, cond_nt_hit;
  logic [31:0]        win_pc, win_tgt;
  logic [FETCH_W-1:0] win_onehot;

  always_comb begin
    win_found   = 1'b0;
    win_call    = 1'b0;
    win_ret     = 1'b0;
    win_cond    = 1'b0;
    cond_nt_hit = 1'b0;
    win_pc      = '0;
    win_tgt     = '0;
    win_onehot  = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      if (!win_found && slot_hit[s] && (s >= int'(start_slot))) begin
        if (slot_taken[s]) begin
          win_found     = 1'b1;
          win_onehot[s] = 1'b1;
          win_call      = btb_call_q[slot_idx[s]];
          win_ret       = btb_ret_q[slot_idx[s]];
          win_cond      = slot_cond[s];
          win_pc        = slot_pc[s];
          win_tgt       = btb_tgt_q[slot_idx[s]];
        end else if (slot_cond[s]) begin
          cond_nt_hit = 1'b1;
        end
      end
    end
  end

  assign next_pc_f_o    = !win_found ? (pc_base + BLK_BYTES) :
                          (win_ret ? ras_q[ras_ptr_spec_q] : win_tgt);
  assign next_taken_f_o = win_onehot;

  // BTB training: hit keeps its slot, miss takes the first free slot or the round-robin victim
  logic             res_taken, src_hit, inv_found;
  logic [BTB_W-1:0] src_idx, inv_idx, wr_idx;

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_call_d  = btb_call_q;
    btb_ret_d   = btb_ret_q;
    btb_jmp_d   = btb_jmp_q;
    btb_pc_d    = btb_pc_q;
    btb_tgt_d   = btb_tgt_q;
    alloc_ptr_d = alloc_ptr_q;
    res_taken   = branch_is_taken_i | branch_is_jmp_i | branch_is_call_i | branch_is_ret_i;
    src_hit     = 1'b0;
    src_idx     = '0;
    inv_found   = 1'b0;
    inv_idx     = '0;
    for (int e = 0; e < BTB_ENTRIES; e++) begin
      if (!src_hit && btb_valid_q[e] && (btb_pc_q[e] == branch_source_i)) begin
        src_hit = 1'b1;
        src_idx = BTB_W'(e);
      end
      if (!inv_found && !btb_valid_q[e]) begin
        inv_found = 1'b1;
        inv_idx   = BTB_W'(e);
      end
    end
    wr_idx = src_hit ? src_idx : (inv_found ? inv_idx : alloc_ptr_q);
    if (branch_request_i && !invalidate_i) begin
      btb_call_d[wr_idx] = branch_is_call_i;
      btb_ret_d[wr_idx]  = branch_is_ret_i;
      btb_jmp_d[wr_idx]  = branch_is_jmp_i;
      if (!src_hit || res_taken) btb_tgt_d[wr_idx] = branch_pc_i;
      if (!src_hit) begin
        btb_valid_d[wr_idx] = 1'b1;
        btb_pc_d[wr_idx]    = branch_source_i;
        if (!inv_found) alloc_ptr_d = (alloc_ptr_q == BTB_LAST) ? '0 : alloc_ptr_q + BTB_W'(1);
      end
    end
    if (invalidate_i) btb_valid_d = '0;
  end

  logic [BHT_W-1:0] upd_idx;
  logic [RAS_W-1:0] push_real, push_spec;

  always_comb begin
    bht_d   = bht_q;
    upd_idx = bht_idx(branch_source_i, ghr_real_q);
    if (branch_is_taken_i && (bht_q[upd_idx] != 2'd3)) begin
      bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
    end else if (branch_is_not_taken_i && (bht_q[upd_idx] != 2'd0)) begin
      bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
    end

    ghr_real_d = ghr_real_q;
    if (branch_is_taken_i || branch_is_not_taken_i) begin
      ghr_real_d = {ghr_real_q[BHT_W-2:0], branch_is_taken_i};
    end

    ras_d          = ras_q;
    ras_ptr_real_d = ras_ptr_real_q;
    ras_cnt_real_d = ras_cnt_real_q;
    ras_ptr_spec_d = ras_ptr_spec_q;
    ras_cnt_spec_d = ras_cnt_spec_q;
    ghr_spec_d     = ghr_spec_q;
    push_real      = ras_ptr_real_q + RAS_W'(1);
    push_spec      = ras_ptr_spec_q + RAS_W'(1);

    // A resolved call lands after a speculative push so the architectural value wins a shared slot
    if (!invalidate_i && !branch_request_i && pc_accept_i && win_found && win_call) begin
      ras_d[push_spec] = win_pc + 32'd4;
    end
    if (branch_is_call_i) begin
      ras_d[push_real] = branch_source_i + 32'd4;
      ras_ptr_real_d   = push_real;
      if (ras_cnt_real_q != RAS_FULL) ras_cnt_real_d = ras_cnt_real_q + 1'b1;
    end else if (branch_is_ret_i && (ras_cnt_real_q != '0)) begin
      ras_ptr_real_d = ras_ptr_real_q - RAS_W'(1);
      ras_cnt_real_d = ras_cnt_real_q - 1'b1;
    end

    if (invalidate_i) begin
      ghr_spec_d     = ghr_real_d;
      ras_ptr_spec_d = ras_ptr_real_d;
      ras_cnt_spec_d = ras_cnt_real_d;
    end else if (branch_request_i) begin
      ghr_spec_d     = {ghr_real_q[BHT_W-2:0], branch_is_taken_i};
      ras_ptr_spec_d = ras_ptr_real_d;
      ras_cnt_spec_d = ras_cnt_real_d;
    end else if (pc_accept_i) begin
      if (win_found && win_cond) begin
        ghr_spec_d = {ghr_spec_q[BHT_W-2:0], 1'b1};
      end else if (cond_nt_hit) begin
        ghr_spec_d = {ghr_spec_q[BHT_W-2:0], 1'b0};
      end
      if (win_found && win_call) begin
        ras_ptr_spec_d = push_spec;
        if (ras_cnt_spec_q != RAS_FULL) ras_cnt_spec_d = ras_cnt_spec_q + 1'b1;
      end else if (win_found && win_ret) begin
        ras_ptr_spec_d = ras_ptr_spec_q - RAS_W'(1);
        ras_cnt_spec_d = ras_cnt_spec_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btb_valid_q    <= '0;
      btb_call_q     <= '0;
      btb_ret_q      <= '0;
      btb_jmp_q      <= '0;
      btb_pc_q       <= '{default: '0};
      btb_tgt_q      <= '{default: '0};
      alloc_ptr_q    <= '0;
      bht_q          <= '{default: BHT_INIT};
      ghr_real_q     <= '0;
      ghr_spec_q     <= '0;
      ras_q          <= '{default: '0};
      ras_ptr_real_q <= '0;
      ras_ptr_spec_q <= '0;
      ras_cnt_real_q <= '0;
      ras_cnt_spec_q <= '0;
    end else begin
      btb_valid_q    <= btb_valid_d;
      btb_call_q     <= btb_call_d;
      btb_ret_q      <= btb_ret_d;
      btb_jmp_q      <= btb_jmp_d;
      btb_pc_q       <= btb_pc_d;
      btb_tgt_q      <= btb_tgt_d;
      alloc_ptr_q    <= alloc_ptr_d;
      bht_q          <= bht_d;
      ghr_real_q     <= ghr_real_d;
      ghr_spec_q     <= ghr_spec_d;
      ras_q          <= ras_d;
      ras_ptr_real_q <= ras_ptr_real_d;
      ras_ptr_spec_q <= ras_ptr_spec_d;
      ras_cnt_real_q <= ras_cnt_real_d;
      ras_cnt_spec_q <= ras_cnt_spec_d;
    end
  end

endmodule
